// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and widths for the FIFO write-port arbiter.
// Holds the FSM state enum, default widths and the stats saturating increment.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  localparam int NUM_REQ_DEF   = 4;
  localparam int DATA_W_DEF    = 32;
  localparam int BURST_LEN_DEF = 4;

  localparam int GRANT_W = $clog2(NUM_REQ_DEF);
  localparam int CNT_W   = $clog2(BURST_LEN_DEF + 1);
  localparam int STATS_W = 16;

  function automatic logic [STATS_W-1:0] sat_inc(
    input logic [STATS_W-1:0] v
  );
    return (&v) ? v : v + STATS_W'(1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake and FIFO write-port bundle.
// slave: arbiter side; master: producers/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_wrt_en;
  logic [DATA_W-1:0]         fifo_data_in;
  logic                      fifo_full;
  logic                      fifo_almost_full;

  modport slave (
    input  req_valid, req_last, req_data,
    input  fifo_full, fifo_almost_full,
    output req_ready, fifo_wrt_en, fifo_data_in
  );

  modport master (
    output req_valid, req_last, req_data,
    output fifo_full, fifo_almost_full,
    input  req_ready, fifo_wrt_en, fifo_data_in
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Circular priority picker: first set req bit after ptr.
// Ports: req (in), ptr (in), idx (out winner), any (out).
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int G_W     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [G_W-1:0]     ptr,
  output logic [G_W-1:0]     idx,
  output logic               any
);

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    int j;
    j   = 0;
    idx = '0;
    any = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[j]) begin
        idx = G_W'(j);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the single FIFO write port.
// Ports: clk, rst (sync, high), bus (slave), grant_id, busy;
// with FIFO_ARB_STATS_EN: stats_sel in, stats_cnt out.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  fifo_wr_arbiter_if.slave           bus,
`ifdef FIFO_ARB_STATS_EN
  input  logic [$clog2(NUM_REQ)-1:0] stats_sel,
  output logic [STATS_W-1:0]         stats_cnt,
`endif
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int G_W = $clog2(NUM_REQ);
  localparam int C_W = $clog2(BURST_LEN + 1);

  state_t             state;
  logic [C_W-1:0]     beat_cnt;
  logic [G_W-1:0]     rr_ptr;
  logic [G_W-1:0]     win;
  logic               any;
  logic               space_ok;
  logic               accept;
  logic               at_end;
  logic [NUM_REQ-1:0] ready;
  logic [DATA_W-1:0]  beat [NUM_REQ];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .G_W     (G_W)
  ) u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .idx (win),
    .any (any)
  );

  // The registered write still in flight consumes the last free slot.
  assign space_ok = !bus.fifo_full &&
                    !(bus.fifo_almost_full && bus.fifo_wrt_en);

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      beat[i] = bus.req_data[i*DATA_W +: DATA_W];
  end

  always_comb begin
    ready = '0;
    if (state == BURST)
      ready[grant_id] = space_ok;
  end

  assign bus.req_ready = ready;
  assign accept = (state == BURST) &&
                  bus.req_valid[grant_id] && space_ok;
  assign at_end = bus.req_last[grant_id] ||
                  (beat_cnt == C_W'(BURST_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      busy             <= 1'b0;
      grant_id         <= '0;
      rr_ptr           <= G_W'(NUM_REQ - 1);
      beat_cnt         <= '0;
      bus.fifo_wrt_en  <= 1'b0;
      bus.fifo_data_in <= '0;
    end else begin
      bus.fifo_wrt_en <= accept;
      if (accept)
        bus.fifo_data_in <= beat[grant_id];
      unique case (state)
        IDLE: begin
          if (any) begin
            grant_id <= win;
            rr_ptr   <= win;
            beat_cnt <= '0;
            state    <= BURST;
            busy     <= 1'b1;
          end
        end
        BURST: begin
          if (!bus.req_valid[grant_id]) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (accept) begin
            if (at_end) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + C_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STATS_W-1:0] cnt [NUM_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++)
        cnt[i] <= '0;
      stats_cnt <= '0;
    end else begin
      if (accept)
        cnt[grant_id] <= sat_inc(cnt[grant_id]);
      stats_cnt <= cnt[stats_sel];
    end
  end
`endif

endmodule
